// File: rtl/ysyx_220053_arb_pkg.sv
// Shared types and default widths for the IF/LS memory arbiter.
package ysyx_220053_arb_pkg;

    localparam int ARB_ADDR_W = 64;
    localparam int ARB_DATA_W = 64;

    // Transaction sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } arb_state_t;

    // Which requester owns the current transaction
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/ysyx_220053_arb_rr_pick.sv
// Combinational two-way round-robin selector: a lone requester always wins,
// and when both ask the one that did not win last time is chosen.
module ysyx_220053_arb_rr_pick
    import ysyx_220053_arb_pkg::*;
(
    input  logic       if_valid,
    input  logic       ls_valid,
    input  arb_owner_t last_grant,
    output logic       grant_valid,
    output arb_owner_t grant_owner
);

    // Pick the winner from the current requests and the previous grant
    always_comb begin
        grant_valid = if_valid | ls_valid;
        grant_owner = OWN_IF;
        if (if_valid && ls_valid) begin
            grant_owner = (last_grant == OWN_IF) ? OWN_LS : OWN_IF;
        end else if (ls_valid) begin
            grant_owner = OWN_LS;
        end
    end

endmodule

// File: rtl/ysyx_220053_mem_arb.sv
// Two-requester arbiter/sequencer for the shared memory port.
// IF (fetch, read-only) and LS (load/store) compete; one transaction is
// granted at a time, issued on the downstream request channel, and its
// response is routed back to the owner.
// Optional: define YSYX_220053_ARB_PERF_EN to add saturating performance
// counters (perf_if_grants, perf_ls_grants, perf_wait_cycles).
module ysyx_220053_mem_arb
    import ysyx_220053_arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W,
    parameter int MASK_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_valid,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic              ls_wen,
    input  logic [DATA_W-1:0] ls_wdata,
    input  logic [MASK_W-1:0] ls_wmask,
    output logic              ls_ready,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef YSYX_220053_ARB_PERF_EN
    ,
    output logic [31:0]       perf_if_grants,
    output logic [31:0]       perf_ls_grants,
    output logic [31:0]       perf_wait_cycles
`endif
);

    arb_state_t        state_q, state_d;
    arb_owner_t        owner_q, owner_d;
    arb_owner_t        last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [MASK_W-1:0] wmask_q, wmask_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;

    logic       pick_valid;
    arb_owner_t pick_owner;

    ysyx_220053_arb_rr_pick u_pick (
        .if_valid    (if_valid),
        .ls_valid    (ls_valid),
        .last_grant  (last_grant_q),
        .grant_valid (pick_valid),
        .grant_owner (pick_owner)
    );

    // Next-state logic: grant in IDLE, issue in REQ, collect in WAIT, notify in DONE.
    // The ready pulses are combinational, so they are also qualified by rst to
    // keep every output low while reset is held.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wen_d        = wen_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        if_rdata_d   = if_rdata_q;
        ls_rdata_d   = ls_rdata_q;
        if_ready     = 1'b0;
        ls_ready     = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid && rst) begin
                    state_d      = REQ;
                    owner_d      = pick_owner;
                    last_grant_d = pick_owner;
                    if (pick_owner == OWN_IF) begin
                        addr_d   = if_addr;
                        wen_d    = 1'b0;
                        wdata_d  = '0;
                        wmask_d  = '0;
                        if_ready = 1'b1;
                    end else begin
                        addr_d   = ls_addr;
                        wen_d    = ls_wen;
                        wdata_d  = ls_wdata;
                        wmask_d  = ls_wen ? ls_wmask : '0;
                        ls_ready = 1'b1;
                    end
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    state_d = DONE;
                    if (owner_q == OWN_IF) begin
                        if_rdata_d = mem_rdata;
                    end else begin
                        ls_rdata_d = mem_rdata;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and transaction registers; reset abandons any in-flight transaction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            owner_q      <= OWN_IF;
            last_grant_q <= OWN_LS;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            if_rdata_q   <= '0;
            ls_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wen_q        <= wen_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
            if_rdata_q   <= if_rdata_d;
            ls_rdata_q   <= ls_rdata_d;
        end
    end

    // Output decode from registered state
    always_comb begin
        mem_req_valid = (state_q == REQ);
        mem_addr      = addr_q;
        mem_wen       = wen_q;
        mem_wdata     = wdata_q;
        mem_wmask     = wmask_q;
        if_rvalid     = (state_q == DONE) && (owner_q == OWN_IF);
        ls_rvalid     = (state_q == DONE) && (owner_q == OWN_LS);
        if_rdata      = if_rdata_q;
        ls_rdata      = ls_rdata_q;
    end

`ifdef YSYX_220053_ARB_PERF_EN
    logic [31:0] perf_if_q, perf_if_d;
    logic [31:0] perf_ls_q, perf_ls_d;
    logic [31:0] perf_wait_q, perf_wait_d;

    // Saturating grant and busy-cycle counters
    always_comb begin
        perf_if_d   = perf_if_q;
        perf_ls_d   = perf_ls_q;
        perf_wait_d = perf_wait_q;
        if (if_ready && (perf_if_q != 32'hFFFF_FFFF)) begin
            perf_if_d = perf_if_q + 32'd1;
        end
        if (ls_ready && (perf_ls_q != 32'hFFFF_FFFF)) begin
            perf_ls_d = perf_ls_q + 32'd1;
        end
        if (((state_q == REQ) || (state_q == WAIT)) && (perf_wait_q != 32'hFFFF_FFFF)) begin
            perf_wait_d = perf_wait_q + 32'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_if_q   <= '0;
            perf_ls_q   <= '0;
            perf_wait_q <= '0;
        end else begin
            perf_if_q   <= perf_if_d;
            perf_ls_q   <= perf_ls_d;
            perf_wait_q <= perf_wait_d;
        end
    end

    assign perf_if_grants   = perf_if_q;
    assign perf_ls_grants   = perf_ls_q;
    assign perf_wait_cycles = perf_wait_q;
`endif

endmodule
